// File: rtl/hack_cpu_mc.sv
// hack_cpu_mc: multi-cycle Hack-style CPU core with separate instruction and data
// req/ack handshakes. The FSM absorbs wait states of any length on either port.
// Optional build macro HACK_CPU_PERF_EN adds cyc_cnt/ret_cnt performance counters.
module hack_cpu_mc #(
    parameter int           W      = 16,
    parameter logic [W-2:0] RST_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    output logic          i_req,
    output logic [W-2:0]  i_addr,
    input  logic          i_ack,
    input  logic [W-1:0]  i_data,
    output logic          d_req,
    output logic          d_we,
    output logic [W-2:0]  d_addr,
    output logic [W-1:0]  d_wdata,
    input  logic          d_ack,
    input  logic [W-1:0]  d_rdata,
    output logic          retire,
`ifdef HACK_CPU_PERF_EN
    output logic [31:0]   cyc_cnt,
    output logic [31:0]   ret_cnt,
`endif
    output logic [W-2:0]  pc,
    output logic [W-1:0]  a_reg,
    output logic [W-1:0]  d_reg
);
    localparam int AW = W - 1;
    localparam logic [AW-1:0] PC_ONE = AW'(1);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_MEMRD, S_EXEC, S_MEMWR} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  d_q, d_d;
    logic [W-1:0]  ir_q, ir_d;
    logic [W-1:0]  mdr_q, mdr_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [W-1:0]  wdata_q, wdata_d;

    // C-instruction fields
    logic c_a, c_zx, c_nx, c_zy, c_ny, c_f, c_no, c_da, c_dd, c_dm;
    assign {c_a, c_zx, c_nx, c_zy, c_ny, c_f, c_no} = ir_q[12:6];
    assign {c_da, c_dd, c_dm} = ir_q[5:3];

    logic [W-1:0] x0, x1, y0, y1, o0, alu_out;
    logic         alu_lt, alu_eq, alu_gt, jump;

    // ALU: x = D, y = A or MDR, with the usual zero/negate/op/negate-out chain
    always_comb begin
        x0      = c_zx ? '0 : d_q;
        x1      = c_nx ? ~x0 : x0;
        y0      = c_zy ? '0 : (c_a ? mdr_q : a_q);
        y1      = c_ny ? ~y0 : y0;
        o0      = c_f ? (x1 + y1) : (x1 & y1);
        alu_out = c_no ? ~o0 : o0;
    end

    assign alu_lt = alu_out[W-1];
    assign alu_eq = (alu_out == '0);
    assign alu_gt = ~alu_lt & ~alu_eq;
    assign jump   = (ir_q[2] & alu_lt) | (ir_q[1] & alu_eq) | (ir_q[0] & alu_gt);

    // Next-state and handshake outputs; reset masks every request and retire
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        a_d     = a_q;
        d_d     = d_q;
        ir_d    = ir_q;
        mdr_d   = mdr_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        i_req   = 1'b0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = a_q[AW-1:0];
        retire  = 1'b0;
        case (state_q)
            S_FETCH: begin
                i_req = 1'b1;
                if (i_ack) begin
                    ir_d    = i_data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!ir_q[W-1]) begin
                    a_d     = {1'b0, ir_q[W-2:0]};
                    pc_d    = pc_q + PC_ONE;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (c_a) begin
                    state_d = S_MEMRD;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_MEMRD: begin
                d_req = 1'b1;
                if (d_ack) begin
                    mdr_d   = d_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // Write address and jump target both come from the pre-instruction A
                waddr_d = a_q[AW-1:0];
                wdata_d = alu_out;
                if (c_dd) d_d = alu_out;
                if (c_da) a_d = alu_out;
                pc_d = jump ? a_q[AW-1:0] : pc_q + PC_ONE;
                if (c_dm) begin
                    state_d = S_MEMWR;
                end else begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEMWR: begin
                d_req  = 1'b1;
                d_we   = 1'b1;
                d_addr = waddr_q;
                if (d_ack) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
        if (!rst) begin
            i_req  = 1'b0;
            d_req  = 1'b0;
            d_we   = 1'b0;
            retire = 1'b0;
        end
    end

    // Architectural and FSM state with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_FETCH;
            pc_q    <= RST_PC;
            a_q     <= '0;
            d_q     <= '0;
            ir_q    <= '0;
            mdr_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            a_q     <= a_d;
            d_q     <= d_d;
            ir_q    <= ir_d;
            mdr_q   <= mdr_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign i_addr  = pc_q;
    assign d_wdata = wdata_q;
    assign pc      = pc_q;
    assign a_reg   = a_q;
    assign d_reg   = d_q;

`ifdef HACK_CPU_PERF_EN
    logic [31:0] cyc_cnt_q, ret_cnt_q;

    // Free-running cycle and retire counters, cleared by reset, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (!rst) begin
            cyc_cnt_q <= '0;
            ret_cnt_q <= '0;
        end else begin
            cyc_cnt_q <= cyc_cnt_q + 32'd1;
            if (retire) ret_cnt_q <= ret_cnt_q + 32'd1;
        end
    end

    assign cyc_cnt = cyc_cnt_q;
    assign ret_cnt = ret_cnt_q;
`endif
endmodule

// File: tb/tb_hack_cpu_mc.sv
// Directed bench for hack_cpu_mc: behavioural imem/dmem responders plus a
// scoreboard of expected {pc, A, D} after each retired instruction.
module tb_hack_cpu_mc;
    logic        clk, rst;
    logic        i_req, i_ack, d_req, d_we, d_ack, retire;
    logic [14:0] i_addr, d_addr, pc;
    logic [15:0] i_data, d_wdata, d_rdata, a_reg, d_reg;
`ifdef HACK_CPU_PERF_EN
    logic [31:0] cyc_cnt, ret_cnt;
`endif

    hack_cpu_mc #(.W(16), .RST_PC(15'd0)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_data(i_data),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .retire(retire),
`ifdef HACK_CPU_PERF_EN
        .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt),
`endif
        .pc(pc), .a_reg(a_reg), .d_reg(d_reg)
    );

    typedef struct {
        logic [14:0] pc;
        logic [15:0] a;
        logic [15:0] d;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] imem[64];
    logic [15:0] dram[256];
    int          errors, checks, cyc, dwait, dcnt;
    bit          d_force;
    logic [14:0] last_raddr, last_waddr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Memory responders decide ack/data on the falling edge
    initial begin
        i_ack = 0; i_data = 0; d_ack = 0; d_rdata = 0; dcnt = 0;
        forever begin
            @(negedge clk);
            i_ack  = i_req;
            i_data = imem[i_addr[5:0]];
            if (d_force) begin
                d_ack = 1'b1;
            end else if (d_req) begin
                if (dcnt >= dwait) begin
                    d_ack = 1'b1;
                    dcnt  = 0;
                    if (d_we) begin
                        dram[d_addr[7:0]] = d_wdata;
                        last_waddr = d_addr;
                    end else begin
                        d_rdata    = dram[d_addr[7:0]];
                        last_raddr = d_addr;
                    end
                end else begin
                    d_ack = 1'b0;
                    dcnt++;
                end
            end else begin
                d_ack = 1'b0;
                dcnt  = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [14:0] p, input logic [15:0] a, input logic [15:0] d);
        exp_t e;
        e.pc = p; e.a = a; e.d = d;
        sb.push_back(e);
    endtask

    task automatic check_sb(input string tag);
        exp_t e;
        chk({tag, " sb nonempty"}, 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, " pc"}, pc, e.pc);
            chk({tag, " a_reg"}, a_reg, e.a);
            chk({tag, " d_reg"}, d_reg, e.d);
        end
    endtask

    // Wait (bounded) for a retire pulse, check its cycle, then check registers
    task automatic wait_retire(input string tag, input int exp_cyc);
        bit seen;
        seen = 0;
        for (int n = 0; n < 40 && !seen; n++) begin
            smp();
            if (retire === 1'b1) seen = 1;
        end
        chk({tag, " retire seen"}, seen, 1);
        chk({tag, " retire cycle"}, cyc, exp_cyc);
        smp();
        check_sb(tag);
    endtask

    task automatic load(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
        for (int i = 0; i < 64; i++) imem[i] = 16'h0000;
        imem[0] = w0; imem[1] = w1; imem[2] = w2;
    endtask

    task automatic do_reset();
        drv_edge();
        rst = 1'b0;
        repeat (2) drv_edge();
    endtask

    task automatic release_rst(output int r);
        drv_edge();
        rst = 1'b1;
        r = cyc;
    endtask

    initial begin
        int r;
        rst = 1'b0; d_force = 0; dwait = 0; errors = 0; checks = 0;
        last_raddr = '0; last_waddr = '0;
        for (int i = 0; i < 256; i++) dram[i] = 16'h0000;
        load(16'h0005, 16'h0000, 16'h0000);

        // Reset state
        repeat (2) drv_edge();
        smp();
        chk("rst pc", pc, 0);
        chk("rst a_reg", a_reg, 0);
        chk("rst d_reg", d_reg, 0);
        chk("rst i_req", i_req, 0);
        chk("rst d_req", d_req, 0);
        chk("rst d_we", d_we, 0);
        chk("rst retire", retire, 0);

        // @5 with zero-wait imem
        push(15'd1, 16'd5, 16'd0);
        release_rst(r);
        wait_retire("t1 @5", r + 1);

        // @7; D=A; D=D+A
        do_reset();
        load(16'h0007, 16'hEC10, 16'hE090);
        push(15'd1, 16'd7, 16'd0);
        push(15'd2, 16'd7, 16'd7);
        push(15'd3, 16'd7, 16'd14);
        release_rst(r);
        wait_retire("t2 @7", r + 1);
        wait_retire("t2 D=A", r + 4);
        wait_retire("t2 D=D+A", r + 7);

        // @100; M=-1 with 3 dmem wait cycles
        do_reset();
        dwait = 3;
        load(16'h0064, 16'hEE88, 16'h0000);
        push(15'd1, 16'd100, 16'd0);
        push(15'd2, 16'd100, 16'd0);
        release_rst(r);
        wait_retire("t3 @100", r + 1);
        repeat (2) smp();
        for (int k = 0; k < 4; k++) begin
            smp();
            chk("t3 d_req", d_req, 1);
            chk("t3 d_we", d_we, 1);
            chk("t3 d_addr", d_addr, 100);
            chk("t3 d_wdata", d_wdata, 16'hFFFF);
            chk("t3 retire", retire, 32'(k == 3));
        end
        smp();
        check_sb("t3 M=-1");
        chk("t3 d_req drop", d_req, 0);
        chk("t3 ram", dram[100], 16'hFFFF);

        // @100; AM=M+1 with RAM[100]=41
        do_reset();
        dwait = 0;
        dram[100] = 16'd41;
        last_raddr = '0; last_waddr = '0;
        load(16'h0064, 16'hFDE8, 16'h0000);
        push(15'd1, 16'd100, 16'd0);
        push(15'd2, 16'd42, 16'd0);
        release_rst(r);
        wait_retire("t4 @100", r + 1);
        wait_retire("t4 AM=M+1", r + 6);
        chk("t4 raddr", last_raddr, 100);
        chk("t4 waddr", last_waddr, 100);
        chk("t4 ram", dram[100], 16'd42);

        // D=-1; @20; D;JLT -> taken
        do_reset();
        load(16'hEE90, 16'h0014, 16'hE304);
        push(15'd1, 16'd0, 16'hFFFF);
        push(15'd2, 16'd20, 16'hFFFF);
        push(15'd20, 16'd20, 16'hFFFF);
        release_rst(r);
        wait_retire("t5 D=-1", r + 2);
        wait_retire("t5 @20", r + 4);
        wait_retire("t5 JLT taken", r + 7);

        // D=0; @20; D;JLT -> not taken
        do_reset();
        load(16'hEA90, 16'h0014, 16'hE304);
        push(15'd1, 16'd0, 16'd0);
        push(15'd2, 16'd20, 16'd0);
        push(15'd3, 16'd20, 16'd0);
        release_rst(r);
        wait_retire("t6 D=0", r + 2);
        wait_retire("t6 @20", r + 4);
        wait_retire("t6 JLT not taken", r + 7);

        // Reset in the middle of a stalled MEMWR, then a late ack
        do_reset();
        dwait = 1000;
        dram[100] = 16'h0000;
        load(16'h0064, 16'hEE88, 16'h0000);
        push(15'd1, 16'd100, 16'd0);
        release_rst(r);
        wait_retire("t7 @100", r + 1);
        repeat (4) smp();
        chk("t7 in MEMWR d_req", d_req, 1);
        drv_edge();
        rst = 1'b0;
        smp();
        chk("t7 d_req masked", d_req, 0);
        chk("t7 i_req masked", i_req, 0);
        smp();
        chk("t7 pc", pc, 0);
        chk("t7 a_reg", a_reg, 0);
        chk("t7 d_reg", d_reg, 0);
        chk("t7 d_req", d_req, 0);
        drv_edge();
        d_force = 1;
        smp();
        chk("t7 late ack retire", retire, 0);
        drv_edge();
        d_force = 0;
        dwait = 0;
        smp();
        chk("t7 pc after ack", pc, 0);
        chk("t7 d_req after ack", d_req, 0);
        chk("t7 ram untouched", dram[100], 16'h0000);
`ifdef HACK_CPU_PERF_EN
        chk("t7 cyc_cnt", cyc_cnt, 0);
        chk("t7 ret_cnt", ret_cnt, 0);
`endif
        push(15'd1, 16'd100, 16'd0);
        release_rst(r);
        wait_retire("t7 restart @100", r + 1);

        chk("sb drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
